// File: rtl/axis_join_arbiter_pkg.sv
// Shared types and helpers for the stream join arbiter and its skid stage.
// Holds the FSM encoding and the wrap-around priority search.
package axis_join_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_XFER,
    ST_DRAIN,
    ST_DONE
  } join_state_t;

  localparam int MAX_PORTS  = 16;
  localparam int PORT_IDX_W = 4;

  typedef struct packed {
    logic                  found;
    logic [PORT_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of cand at or after ptr, wrapping at count. Iterating from the
  // farthest offset down lets the nearest candidate overwrite the result.
  function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0]  cand,
                                       input logic [PORT_IDX_W-1:0] ptr,
                                       input int                    count);
    rr_pick_t res;
    int       j;
    res = '0;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (i < count) begin
        j = int'(ptr) + i;
        if (j >= count) j = j - count;
        if (cand[j[PORT_IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j[PORT_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_join_arbiter_skid.sv
// Two-entry AXI4-Stream skid register with a registered input ready.
// Full throughput under continuous ready; output payload holds while stalled.
module axis_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             in_fire;

  // Ready is a pure flop output, so nothing on the output side reaches it combinationally.
  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & in_ready;
  assign busy     = out_valid | skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) out_data <= in_data;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/axis_join_arbiter.sv
// Collects one packet from each input stream, round-robin, into one output stream.
// state | meaning: IDLE wait for enable | ARB pick next port | XFER forward packet | DRAIN empty output | DONE report
module axis_join_arbiter
  import axis_join_arbiter_pkg::*;
#(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          join_enable,
  output logic                          join_done,
  output logic [M_COUNT-1:0]            s_axis_tready,
  input  logic [M_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [M_COUNT-1:0]            s_axis_tlast,
  input  logic [M_COUNT-1:0]            s_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  output logic [ID_WIDTH-1:0]           m_axis_tid
);

  localparam int PW = DATA_WIDTH + ID_WIDTH + 1;
  localparam logic [M_COUNT-1:0] ALL_SERVED = {M_COUNT{1'b1}};

  join_state_t           state;
  logic [M_COUNT-1:0]    served;
  logic [M_COUNT-1:0]    served_nxt;
  logic [PORT_IDX_W-1:0] ptr;
  logic [PORT_IDX_W-1:0] grant;
  logic [PORT_IDX_W-1:0] grant_inc;
  rr_pick_t              pick;

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  beat_fire;

  logic                  sk_in_valid;
  logic                  sk_in_ready;
  logic [PW-1:0]         sk_in_data;
  logic [PW-1:0]         sk_out_data;
  logic                  sk_busy;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int p = 0; p < M_COUNT; p++) begin
      if (grant == PORT_IDX_W'(p)) begin
        sel_valid = s_axis_tvalid[p];
        sel_last  = s_axis_tlast[p];
        sel_data  = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    for (int p = 0; p < M_COUNT; p++) begin
      s_axis_tready[p] = (state == ST_XFER) && sk_in_ready && (grant == PORT_IDX_W'(p));
    end
  end

  assign sk_in_valid = (state == ST_XFER) && sel_valid;
  assign beat_fire   = sk_in_valid && sk_in_ready;
  assign sk_in_data  = {ID_WIDTH'(grant), sel_last, sel_data};
  assign served_nxt  = served | (M_COUNT'(1) << grant);
  assign grant_inc   = (grant == PORT_IDX_W'(M_COUNT - 1)) ? '0 : grant + 1'b1;
  // Ports that already delivered this pass are masked out even while they stay valid.
  assign pick        = rr_pick(MAX_PORTS'(s_axis_tvalid & ~served), ptr, M_COUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      served    <= '0;
      ptr       <= '0;
      grant     <= '0;
      join_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (join_enable) begin
            served <= '0;
            ptr    <= '0;
            state  <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (pick.found) begin
            grant <= pick.idx;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (beat_fire && sel_last) begin
            served <= served_nxt;
            ptr    <= grant_inc;
            state  <= (served_nxt == ALL_SERVED) ? ST_DRAIN : ST_ARB;
          end
        end
        ST_DRAIN: begin
          if (!sk_busy) begin
            join_done <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!join_enable) begin
            join_done <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axis_skid_reg #(
    .WIDTH(PW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (sk_in_valid),
    .in_ready (sk_in_ready),
    .in_data  (sk_in_data),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready),
    .out_data (sk_out_data),
    .busy     (sk_busy)
  );

  assign m_axis_tid   = sk_out_data[PW-1 -: ID_WIDTH];
  assign m_axis_tlast = sk_out_data[DATA_WIDTH];
  assign m_axis_tdata = sk_out_data[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_axis_join_arbiter.sv
// Scoreboard bench for the join arbiter: per-port source queues, expected beats
// queued in the order the round-robin should deliver them.
module tb_axis_join_arbiter;
  import axis_join_arbiter_pkg::*;

  localparam int M  = 4;
  localparam int DW = 64;
  localparam int IW = 2;
  localparam int PW = DW + IW + 1;
  localparam int CW = PW + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            join_enable = 1'b0;
  logic            join_done;
  logic [M-1:0]    s_axis_tready;
  logic [M*DW-1:0] s_axis_tdata = '0;
  logic [M-1:0]    s_axis_tlast = '0;
  logic [M-1:0]    s_axis_tvalid = '0;
  logic            m_axis_tready = 1'b1;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tlast;
  logic            m_axis_tvalid;
  logic [IW-1:0]   m_axis_tid;

  always #5 clk = ~clk;

  axis_join_arbiter #(
    .M_COUNT(M), .DATA_WIDTH(DW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .join_enable(join_enable), .join_done(join_done),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tid(m_axis_tid)
  );

  logic [DW:0]   src_q [M][$];
  logic [PW-1:0] exp_q [$];

  int total = 0;
  int bad = 0;
  int beats_out, lasts_out, pushed, edge_cnt, last_accept_edge, done_edge;
  int acc_cnt [M];
  bit done_seen, hold_pending, rdy_toggle;
  logic [CW-1:0] hold_pl;
  logic en_next = 1'b0;
  logic rst_next = 1'b1;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic start_test();
    beats_out = 0; lasts_out = 0; pushed = 0; done_seen = 1'b0;
    last_accept_edge = 0; done_edge = 0;
    for (int p = 0; p < M; p++) acc_cnt[p] = 0;
  endtask

  task automatic add_packet(input int p, input int len, input bit expect_out);
    logic [DW-1:0] d;
    logic          l;
    for (int b = 0; b < len; b++) begin
      d = {$urandom, $urandom};
      l = (b == len - 1);
      src_q[p].push_back({l, d});
      if (expect_out) begin
        exp_q.push_back({IW'(p), l, d});
        pushed++;
      end
    end
  endtask

  task automatic tick();
    logic [M-1:0]  s_fire;
    logic          m_fire;
    logic [CW-1:0] m_pl;
    @(negedge clk);
    rst = rst_next;
    join_enable = en_next;
    for (int p = 0; p < M; p++) begin
      if (src_q[p].size() > 0) begin
        s_axis_tvalid[p]         = 1'b1;
        s_axis_tlast[p]          = src_q[p][0][DW];
        s_axis_tdata[p*DW +: DW] = src_q[p][0][DW-1:0];
      end else begin
        s_axis_tvalid[p]         = 1'b0;
        s_axis_tlast[p]          = 1'b0;
        s_axis_tdata[p*DW +: DW] = '0;
      end
    end
    m_axis_tready = rdy_toggle ? ~m_axis_tready : 1'b1;
    #1;
    s_fire = s_axis_tvalid & s_axis_tready;
    m_fire = m_axis_tvalid & m_axis_tready;
    m_pl   = {m_axis_tvalid, m_axis_tid, m_axis_tlast, m_axis_tdata};
    if (hold_pending) check("hold", m_pl, hold_pl);
    hold_pending = m_axis_tvalid & ~m_axis_tready;
    hold_pl      = m_pl;
    if (join_done && !done_seen) begin
      done_seen = 1'b1;
      done_edge = edge_cnt;
    end
    if (m_fire) begin
      beats_out++;
      if (m_axis_tlast) lasts_out++;
      last_accept_edge = edge_cnt + 1;
      if (exp_q.size() == 0) check("sb_extra", CW'(beats_out), CW'(pushed));
      else check("beat", m_pl, {1'b1, exp_q.pop_front()});
    end
    @(posedge clk);
    edge_cnt++;
    for (int p = 0; p < M; p++) begin
      if (s_fire[p]) begin
        void'(src_q[p].pop_front());
        acc_cnt[p]++;
      end
    end
  endtask

  task automatic run_pass(input int budget);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      tick();
      n++;
    end
    check("timeout", CW'(done_seen), CW'(1));
  endtask

  task automatic finish_pass(input int exp_beats, input int exp_lasts);
    check("done_lat", CW'(done_edge - last_accept_edge), CW'(1));
    check("sb_left", CW'(exp_q.size()), CW'(0));
    check("beats", CW'(beats_out), CW'(exp_beats));
    check("lasts", CW'(lasts_out), CW'(exp_lasts));
  endtask

  task automatic end_pass();
    en_next = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    check({tag, "_tvalid"}, CW'(m_axis_tvalid), CW'(0));
    check({tag, "_tlast"}, CW'(m_axis_tlast), CW'(0));
    check({tag, "_tdata"}, CW'(m_axis_tdata), CW'(0));
    check({tag, "_tid"}, CW'(m_axis_tid), CW'(0));
    check({tag, "_done"}, CW'(join_done), CW'(0));
    check({tag, "_sready"}, CW'(s_axis_tready), CW'(0));
    check({tag, "_state"}, CW'(dut.state), CW'(ST_IDLE));
  endtask

  initial begin
    int n, tot_beats;
    edge_cnt = 0; hold_pending = 1'b0; rdy_toggle = 1'b0;
    start_test();

    rst_next = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_next = 1'b0;
    tick();

    // all ports valid, 3-beat packets, order 0..3
    start_test();
    for (int p = 0; p < M; p++) add_packet(p, 3, 1'b1);
    en_next = 1'b1;
    run_pass(300);
    finish_pass(12, 4);
    end_pass();

    // port 2 alone first, the rest 20 cycles later: order 2,3,0,1
    start_test();
    add_packet(2, 3, 1'b1);
    en_next = 1'b1;
    repeat (20) tick();
    check("early_done", CW'(done_seen), CW'(0));
    check("early_beats", CW'(beats_out), CW'(3));
    add_packet(3, 2, 1'b1);
    add_packet(0, 2, 1'b1);
    add_packet(1, 2, 1'b1);
    run_pass(300);
    finish_pass(9, 4);
    end_pass();

    // toggling downstream ready, random lengths including a single-beat packet
    start_test();
    rdy_toggle = 1'b1;
    tot_beats = 1;
    add_packet(0, 1, 1'b1);
    for (int p = 1; p < M; p++) begin
      n = int'($urandom_range(5, 1));
      tot_beats += n;
      add_packet(p, n, 1'b1);
    end
    en_next = 1'b1;
    run_pass(400);
    finish_pass(tot_beats, 4);
    rdy_toggle = 1'b0;
    end_pass();
    hold_pending = 1'b0;

    // port 1 offers two packets; only the first is taken
    start_test();
    add_packet(0, 2, 1'b1);
    add_packet(1, 2, 1'b1);
    add_packet(1, 2, 1'b0);
    add_packet(2, 1, 1'b1);
    add_packet(3, 2, 1'b1);
    en_next = 1'b1;
    run_pass(300);
    finish_pass(7, 4);
    repeat (3) tick();
    #1;
    check("p1_rdy", CW'(s_axis_tready[1]), CW'(0));
    check("p1_valid", CW'(s_axis_tvalid[1]), CW'(1));
    check("p1_left", CW'(src_q[1].size()), CW'(2));
    end_pass();
    src_q[1].delete();
    tick();

    // reset while port 0 is mid-packet (after beat 2 of 5)
    start_test();
    add_packet(0, 5, 1'b1);
    en_next = 1'b1;
    n = 0;
    while (acc_cnt[0] < 2 && n < 50) begin
      tick();
      n++;
    end
    check("rst_mid_acc", CW'(acc_cnt[0]), CW'(2));
    en_next = 1'b0;
    rst_next = 1'b1;
    src_q[0].delete();
    tick();
    exp_q.delete();
    hold_pending = 1'b0;
    check_reset_outputs("rst_mid");
    rst_next = 1'b0;
    tick();
    start_test();
    for (int p = 0; p < M; p++) add_packet(p, 2, 1'b1);
    en_next = 1'b1;
    run_pass(300);
    finish_pass(8, 4);

    // enable held after DONE, then dropped, then a short pulse starts a new pass
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      check("done_hold", CW'(join_done), CW'(1));
    end
    en_next = 1'b0;
    tick();
    #1;
    check("done_fall", CW'(join_done), CW'(0));
    tick();
    start_test();
    for (int p = 0; p < M; p++) add_packet(p, 2, 1'b1);
    en_next = 1'b1;
    tick();
    tick();
    en_next = 1'b0;
    run_pass(300);
    finish_pass(8, 4);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
